// File: rtl/wr_buffer_mc_if.sv
// AXI write-master bundle (AW + W channels) shared by wr_buffer_mc and its consumer.
interface wr_buffer_mc_if #(
    parameter int AXI_DATA_WIDTH = 128,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int ID_WIDTH       = 2
);
    logic                      axi_aw_ready;
    logic                      axi_aw_req_en;
    logic [7:0]                axi_aw_burst_len;
    logic [AXI_ADDR_WIDTH-1:0] axi_aw_addr;
    logic [ID_WIDTH-1:0]       axi_aw_id;
    logic                      axi_w_ready;
    logic                      axi_w_valid;
    logic [AXI_DATA_WIDTH-1:0] axi_w_data;
    logic                      axi_w_last;

    modport master (
        input  axi_aw_ready, axi_w_ready,
        output axi_aw_req_en, axi_aw_burst_len, axi_aw_addr, axi_aw_id,
        output axi_w_valid, axi_w_data, axi_w_last
    );

    modport slave (
        output axi_aw_ready, axi_w_ready,
        input  axi_aw_req_en, axi_aw_burst_len, axi_aw_addr, axi_aw_id,
        input  axi_w_valid, axi_w_data, axi_w_last
    );
endinterface

// File: rtl/wr_buffer_mc.sv
// Multi-channel write buffer: per-channel cmd/data FIFOs, round-robin onto one AXI write master.
// Define WR_BUF_SAF_EN for store-and-forward gating; default build is cut-through.
module wr_buffer_mc #(
    parameter int NUM_CH         = 4,
    parameter int AXI_DATA_WIDTH = 128,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int CMD_DEPTH      = 16,
    parameter int DATA_DEPTH     = 512
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [NUM_CH-1:0]                   wr_req_en,
    input  logic [8*NUM_CH-1:0]                 wr_burst_length,
    input  logic [AXI_ADDR_WIDTH*NUM_CH-1:0]    wr_data_addr,
    output logic [NUM_CH-1:0]                   wr_cmd_ready,
    input  logic [AXI_DATA_WIDTH*NUM_CH-1:0]    wr_data_din,
    input  logic [NUM_CH-1:0]                   wr_data_valid,
    input  logic [NUM_CH-1:0]                   wr_data_last,
    output logic [NUM_CH-1:0]                   wr_data_ready,
    wr_buffer_mc_if.master                      axi,
    output logic [NUM_CH-1:0]                   wr_data_fifo_err,
    output logic [NUM_CH-1:0]                   wr_cmd_fifo_err,
    output logic [NUM_CH-1:0]                   wr_last_err
);
    localparam int ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CAW  = $clog2(CMD_DEPTH);
    localparam int CCW  = CAW + 1;
    localparam int DAW  = $clog2(DATA_DEPTH);
    localparam int DCW  = DAW + 1;
    localparam int CW   = 8 + AXI_ADDR_WIDTH;
    localparam int DWW  = AXI_DATA_WIDTH + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_AW   = 2'd1;
    localparam logic [1:0] ST_W    = 2'd2;

    logic [CW-1:0]   cmd_mem  [NUM_CH][CMD_DEPTH];
    logic [DWW-1:0]  data_mem [NUM_CH][DATA_DEPTH];
    logic [CAW-1:0]  cmd_wr_ptr_r  [NUM_CH];
    logic [CAW-1:0]  cmd_rd_ptr_r  [NUM_CH];
    logic [CCW-1:0]  cmd_cnt_r     [NUM_CH];
    logic [DAW-1:0]  data_wr_ptr_r [NUM_CH];
    logic [DAW-1:0]  data_rd_ptr_r [NUM_CH];
    logic [DCW-1:0]  data_cnt_r    [NUM_CH];
    logic [CW-1:0]   cmd_head_s    [NUM_CH];
    logic [DWW-1:0]  data_head_s   [NUM_CH];

    logic [NUM_CH-1:0] cmd_push_s, cmd_pop_s, cmd_full_s, cmd_empty_s;
    logic [NUM_CH-1:0] data_push_s, data_pop_s, data_full_s, data_empty_s;
    logic [NUM_CH-1:0] elig_s;
    logic [NUM_CH-1:0] data_err_r, cmd_err_r, last_err_r;

    logic [1:0]      state_r;
    logic [ID_W-1:0] grant_r, rr_ptr_r, rr_next_s, pick_s, idx_s;
    logic            pick_vld_s;
    logic [7:0]      beat_cnt_r, len_reg_r;
    logic            aw_vld_s, aw_hs_s, w_valid_s, w_last_s, w_hs_s;

    // FIFO status, heads and push/pop strobes per channel
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cmd_full_s[i]   = (cmd_cnt_r[i] == CCW'(CMD_DEPTH));
            cmd_empty_s[i]  = ~|cmd_cnt_r[i];
            data_full_s[i]  = (data_cnt_r[i] == DCW'(DATA_DEPTH));
            data_empty_s[i] = ~|data_cnt_r[i];
            cmd_head_s[i]   = cmd_mem[i][cmd_rd_ptr_r[i]];
            data_head_s[i]  = data_mem[i][data_rd_ptr_r[i]];
            cmd_push_s[i]   = wr_req_en[i] & ~cmd_full_s[i];
            data_push_s[i]  = wr_data_valid[i] & ~data_full_s[i];
            cmd_pop_s[i]    = aw_hs_s & (grant_r == ID_W'(i));
            data_pop_s[i]   = w_hs_s & (grant_r == ID_W'(i));
        end
    end

`ifdef WR_BUF_SAF_EN
    logic [31:0] need_s [NUM_CH];

    // Store-and-forward: wait until the whole burst (or a full FIFO) is buffered
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            need_s[i] = (({24'd0, cmd_head_s[i][CW-1 -: 8]} + 32'd1) > 32'(DATA_DEPTH)) ?
                        32'(DATA_DEPTH) : ({24'd0, cmd_head_s[i][CW-1 -: 8]} + 32'd1);
            elig_s[i] = ~cmd_empty_s[i] & (32'(data_cnt_r[i]) >= need_s[i]);
        end
    end
`else
    // Cut-through: a queued command is enough
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            elig_s[i] = ~cmd_empty_s[i];
        end
    end
`endif

    // Round-robin pick: first eligible channel at or after rr_ptr_r
    always_comb begin
        pick_vld_s = 1'b0;
        pick_s     = {ID_W{1'b0}};
        idx_s      = {ID_W{1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
            idx_s = ID_W'((int'(rr_ptr_r) + k) % NUM_CH);
            if (!pick_vld_s && elig_s[idx_s]) begin
                pick_vld_s = 1'b1;
                pick_s     = idx_s;
            end else begin
                pick_s     = pick_s;
            end
        end
    end

    // AXI-facing combinational outputs; fields are zero whenever not valid
    always_comb begin
        aw_vld_s  = (state_r == ST_AW);
        aw_hs_s   = aw_vld_s & axi.axi_aw_ready;
        w_valid_s = (state_r == ST_W) & ~data_empty_s[grant_r];
        w_last_s  = w_valid_s & (beat_cnt_r == len_reg_r);
        w_hs_s    = w_valid_s & axi.axi_w_ready;
        rr_next_s = (grant_r == ID_W'(NUM_CH - 1)) ? {ID_W{1'b0}} : grant_r + ID_W'(1'b1);
        axi.axi_aw_req_en    = aw_vld_s;
        axi.axi_aw_burst_len = aw_vld_s ? cmd_head_s[grant_r][CW-1 -: 8] : 8'd0;
        axi.axi_aw_addr      = aw_vld_s ? cmd_head_s[grant_r][AXI_ADDR_WIDTH-1:0] : {AXI_ADDR_WIDTH{1'b0}};
        axi.axi_aw_id        = aw_vld_s ? grant_r : {ID_W{1'b0}};
        axi.axi_w_valid      = w_valid_s;
        axi.axi_w_data       = w_valid_s ? data_head_s[grant_r][AXI_DATA_WIDTH-1:0] : {AXI_DATA_WIDTH{1'b0}};
        axi.axi_w_last       = w_last_s;
    end

    // Arbitration FSM: IDLE -> AW -> W -> IDLE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            grant_r    <= {ID_W{1'b0}};
            rr_ptr_r   <= {ID_W{1'b0}};
            beat_cnt_r <= 8'd0;
            len_reg_r  <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_vld_s) begin
                        grant_r <= pick_s;
                        state_r <= ST_AW;
                    end
                end
                ST_AW: begin
                    if (aw_hs_s) begin
                        beat_cnt_r <= 8'd0;
                        len_reg_r  <= cmd_head_s[grant_r][CW-1 -: 8];
                        state_r    <= ST_W;
                    end
                end
                ST_W: begin
                    if (w_hs_s) begin
                        beat_cnt_r <= beat_cnt_r + 8'd1;
                        if (w_last_s) begin
                            rr_ptr_r <= rr_next_s;
                            state_r  <= ST_IDLE;
                        end
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // FIFO pointers and occupancy counts
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cmd_wr_ptr_r[i]  <= {CAW{1'b0}};
                cmd_rd_ptr_r[i]  <= {CAW{1'b0}};
                cmd_cnt_r[i]     <= {CCW{1'b0}};
                data_wr_ptr_r[i] <= {DAW{1'b0}};
                data_rd_ptr_r[i] <= {DAW{1'b0}};
                data_cnt_r[i]    <= {DCW{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cmd_push_s[i])  cmd_wr_ptr_r[i]  <= cmd_wr_ptr_r[i] + CAW'(1'b1);
                if (cmd_pop_s[i])   cmd_rd_ptr_r[i]  <= cmd_rd_ptr_r[i] + CAW'(1'b1);
                if (data_push_s[i]) data_wr_ptr_r[i] <= data_wr_ptr_r[i] + DAW'(1'b1);
                if (data_pop_s[i])  data_rd_ptr_r[i] <= data_rd_ptr_r[i] + DAW'(1'b1);
                cmd_cnt_r[i]  <= cmd_cnt_r[i] + CCW'(cmd_push_s[i]) - CCW'(cmd_pop_s[i]);
                data_cnt_r[i] <= data_cnt_r[i] + DCW'(data_push_s[i]) - DCW'(data_pop_s[i]);
            end
        end
    end

    // FIFO storage; contents are don't-care while the count says empty
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (cmd_push_s[i])
                cmd_mem[i][cmd_wr_ptr_r[i]] <= {wr_burst_length[i*8 +: 8],
                                                wr_data_addr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH]};
            if (data_push_s[i])
                data_mem[i][data_wr_ptr_r[i]] <= {wr_data_last[i],
                                                  wr_data_din[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH]};
        end
    end

    // Sticky error flags: overflow drops and user-last vs generated-wlast disagreement
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_err_r <= {NUM_CH{1'b0}};
            cmd_err_r  <= {NUM_CH{1'b0}};
            last_err_r <= {NUM_CH{1'b0}};
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_data_valid[i] && data_full_s[i]) data_err_r[i] <= 1'b1;
                if (wr_req_en[i] && cmd_full_s[i])      cmd_err_r[i]  <= 1'b1;
            end
            if (w_hs_s && (data_head_s[grant_r][DWW-1] != w_last_s))
                last_err_r[grant_r] <= 1'b1;
        end
    end

    assign wr_cmd_ready     = ~cmd_full_s;
    assign wr_data_ready    = ~data_full_s;
    assign wr_data_fifo_err = data_err_r;
    assign wr_cmd_fifo_err  = cmd_err_r;
    assign wr_last_err      = last_err_r;
endmodule

// File: tb/tb_wr_buffer_mc.sv
// Directed, table-driven bench for wr_buffer_mc (4 channels, 64-bit data, 16-deep FIFOs).
module tb_wr_buffer_mc;
    localparam int NCH = 4;
    localparam int DW  = 64;
    localparam int AW  = 32;

    typedef struct packed { logic [1:0] id; logic [7:0] len; logic [31:0] addr; } aw_rec_t;
    typedef struct packed { logic [63:0] data; logic last; } w_rec_t;
    typedef struct { int ch; logic [7:0] len; logic [31:0] addr; logic [1:0] exp_id; int exp_beats; } vec_t;

    logic               clk, reset_n;
    logic [NCH-1:0]     wr_req_en, wr_cmd_ready, wr_data_valid, wr_data_last, wr_data_ready;
    logic [8*NCH-1:0]   wr_burst_length;
    logic [AW*NCH-1:0]  wr_data_addr;
    logic [DW*NCH-1:0]  wr_data_din;
    logic [NCH-1:0]     wr_data_fifo_err, wr_cmd_fifo_err, wr_last_err;

    wr_buffer_mc_if #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .ID_WIDTH(2)) axi ();

    wr_buffer_mc #(.NUM_CH(NCH), .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW),
                   .CMD_DEPTH(16), .DATA_DEPTH(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .wr_req_en(wr_req_en), .wr_burst_length(wr_burst_length), .wr_data_addr(wr_data_addr),
        .wr_cmd_ready(wr_cmd_ready), .wr_data_din(wr_data_din), .wr_data_valid(wr_data_valid),
        .wr_data_last(wr_data_last), .wr_data_ready(wr_data_ready), .axi(axi),
        .wr_data_fifo_err(wr_data_fifo_err), .wr_cmd_fifo_err(wr_cmd_fifo_err),
        .wr_last_err(wr_last_err)
    );

    int checks = 0;
    int failures = 0;
    aw_rec_t aw_q[$];
    w_rec_t  w_q[$];
    logic    aw_pend = 1'b0;
    aw_rec_t aw_hold;
    vec_t    vecs[4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pat(input int ch, input int beat, input logic [7:0] tag);
        return {8'(ch), tag, 16'h0, 32'(beat)};
    endfunction

    function automatic aw_rec_t get_aw(input int i);
        aw_rec_t r;
        r = '0;
        if (i < aw_q.size()) r = aw_q[i];
        return r;
    endfunction

    function automatic w_rec_t get_w(input int i);
        w_rec_t r;
        r = '0;
        if (i < w_q.size()) r = w_q[i];
        return r;
    endfunction

    task automatic push_data(input int ch, input logic [63:0] d, input logic l);
        wr_data_valid[2'(ch)]     = 1'b1;
        wr_data_last[2'(ch)]      = l;
        wr_data_din[ch*DW +: DW]  = d;
        tick();
        wr_data_valid = 4'b0;
        wr_data_last  = 4'b0;
    endtask

    task automatic push_cmd(input int ch, input logic [7:0] len, input logic [31:0] addr);
        wr_req_en[2'(ch)]            = 1'b1;
        wr_burst_length[ch*8 +: 8]   = len;
        wr_data_addr[ch*AW +: AW]    = addr;
        tick();
        wr_req_en = 4'b0;
    endtask

    task automatic wait_w(input int n, input int budget, input string nm);
        int k = 0;
        while (w_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk(nm, 64'(w_q.size()), 64'(n));
    endtask

    task automatic check_burst(input int aw_i, input int w_base, input int ch,
                               input logic [7:0] len, input logic [31:0] addr, input logic [7:0] tag);
        aw_rec_t a;
        w_rec_t  w;
        a = get_aw(aw_i);
        chk("aw_id", 64'(a.id), 64'(ch));
        chk("aw_len", 64'(a.len), 64'(len));
        chk("aw_addr", 64'(a.addr), 64'(addr));
        for (int b = 0; b <= int'(len); b++) begin
            w = get_w(w_base + b);
            chk("w_data", w.data, pat(ch, b, tag));
            chk("w_last", 64'(w.last), 64'(b == int'(len)));
        end
    endtask

    task automatic check_quiet(input string nm);
        chk({nm, "_aw_valid"}, 64'(axi.axi_aw_req_en), 64'd0);
        chk({nm, "_w_valid"}, 64'(axi.axi_w_valid), 64'd0);
        chk({nm, "_w_data"}, axi.axi_w_data, 64'd0);
        chk({nm, "_w_last"}, 64'(axi.axi_w_last), 64'd0);
        chk({nm, "_aw_addr"}, 64'(axi.axi_aw_addr), 64'd0);
    endtask

    // Handshake capture at the falling edge, plus AW hold-while-stalled check
    always @(negedge clk) begin
        if (!reset_n) begin
            aw_pend = 1'b0;
        end else begin
            if (aw_pend)
                chk("aw_hold", 64'({axi.axi_aw_req_en, axi.axi_aw_id, axi.axi_aw_burst_len, axi.axi_aw_addr}),
                    64'({1'b1, aw_hold}));
            if (axi.axi_aw_req_en && axi.axi_aw_ready)
                aw_q.push_back({axi.axi_aw_id, axi.axi_aw_burst_len, axi.axi_aw_addr});
            if (axi.axi_w_valid && axi.axi_w_ready)
                w_q.push_back({axi.axi_w_data, axi.axi_w_last});
            aw_pend = axi.axi_aw_req_en && !axi.axi_aw_ready;
            aw_hold = {axi.axi_aw_id, axi.axi_aw_burst_len, axi.axi_aw_addr};
        end
    end

    initial begin
        int k;
        vecs[0] = '{ch: 1, len: 8'd0, addr: 32'h2000, exp_id: 2'd1, exp_beats: 1};
        vecs[1] = '{ch: 2, len: 8'd2, addr: 32'h3000, exp_id: 2'd2, exp_beats: 3};
        vecs[2] = '{ch: 0, len: 8'd5, addr: 32'h1800, exp_id: 2'd0, exp_beats: 6};
        vecs[3] = '{ch: 3, len: 8'd1, addr: 32'h3c00, exp_id: 2'd3, exp_beats: 2};

        reset_n = 1'b0;
        wr_req_en = 4'b0; wr_burst_length = '0; wr_data_addr = '0;
        wr_data_din = '0; wr_data_valid = 4'b0; wr_data_last = 4'b0;
        axi.axi_aw_ready = 1'b0;
        axi.axi_w_ready  = 1'b0;
        repeat (3) tick();
        check_quiet("rst");
        chk("rst_errs", 64'({wr_data_fifo_err, wr_cmd_fifo_err, wr_last_err}), 64'd0);
        reset_n = 1'b1;
        tick();
        chk("rst_cmd_ready", 64'(wr_cmd_ready), 64'hF);
        chk("rst_data_ready", 64'(wr_data_ready), 64'hF);

        // Single burst on ch0 with latency check
        for (int b = 0; b < 4; b++) push_data(0, pat(0, b, 8'h10), b == 3);
        push_cmd(0, 8'd3, 32'h1000);
        chk("lat_n1", 64'(axi.axi_aw_req_en), 64'd0);
        tick();
        chk("lat_n2", 64'(axi.axi_aw_req_en), 64'd1);
        chk("lat_addr", 64'(axi.axi_aw_addr), 64'h1000);
        chk("lat_len", 64'(axi.axi_aw_burst_len), 64'd3);
        chk("lat_id", 64'(axi.axi_aw_id), 64'd0);
        axi.axi_aw_ready = 1'b1;
        axi.axi_w_ready  = 1'b1;
        wait_w(4, 40, "b0_beats");
        check_burst(0, 0, 0, 8'd3, 32'h1000, 8'h10);
        repeat (2) tick();
        check_quiet("b0_idle");

        // Table of single-channel bursts; last entry on ch3 leaves rr at 0
        for (int v = 0; v < 4; v++) begin
            aw_q.delete(); w_q.delete();
            for (int b = 0; b < vecs[v].exp_beats; b++)
                push_data(vecs[v].ch, pat(vecs[v].ch, b, 8'(8'h20 + v)), b == int'(vecs[v].len));
            push_cmd(vecs[v].ch, vecs[v].len, vecs[v].addr);
            wait_w(vecs[v].exp_beats, 60, "vec_beats");
            chk("vec_aw_count", 64'(aw_q.size()), 64'd1);
            check_burst(0, 0, int'(vecs[v].exp_id), vecs[v].len, vecs[v].addr, 8'(8'h20 + v));
            repeat (2) tick();
        end

        // Round robin: all four channels at once, then a late ch0 command
        aw_q.delete(); w_q.delete();
        for (int b = 0; b < 2; b++) begin
            wr_data_valid = 4'hF;
            wr_data_last  = (b == 1) ? 4'hF : 4'h0;
            for (int i = 0; i < NCH; i++) wr_data_din[i*DW +: DW] = pat(i, b, 8'h40);
            tick();
            wr_data_valid = 4'h0; wr_data_last = 4'h0;
        end
        wr_req_en = 4'hF;
        for (int i = 0; i < NCH; i++) begin
            wr_burst_length[i*8 +: 8] = 8'd1;
            wr_data_addr[i*AW +: AW]  = 32'h4000 + 32'(i) * 32'h100;
        end
        tick();
        wr_req_en = 4'h0;
        k = 0;
        while (aw_q.size() < 4 && k < 60) begin tick(); k++; end
        chk("rr_four_aw", 64'(aw_q.size()), 64'd4);
        for (int b = 0; b < 2; b++) push_data(0, pat(0, b, 8'h41), b == 1);
        push_cmd(0, 8'd1, 32'h4800);
        wait_w(10, 80, "rr_beats");
        chk("rr_aw_count", 64'(aw_q.size()), 64'd5);
        for (int i = 0; i < 4; i++) check_burst(i, 2*i, i, 8'd1, 32'h4000 + 32'(i) * 32'h100, 8'h40);
        check_burst(4, 8, 0, 8'd1, 32'h4800, 8'h41);
        repeat (2) tick();

        // AW backpressure then toggling W ready
        aw_q.delete(); w_q.delete();
        axi.axi_aw_ready = 1'b0;
        axi.axi_w_ready  = 1'b0;
        for (int b = 0; b < 4; b++) push_data(1, pat(1, b, 8'h50), b == 3);
        push_cmd(1, 8'd3, 32'h5000);
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("stall_valid", 64'(axi.axi_aw_req_en), 64'd1);
            chk("stall_fields", 64'({axi.axi_aw_id, axi.axi_aw_burst_len, axi.axi_aw_addr}),
                64'({2'd1, 8'd3, 32'h5000}));
            tick();
        end
        axi.axi_aw_ready = 1'b1;
        tick();
        axi.axi_aw_ready = 1'b0;
        chk("stall_aw_done", 64'(axi.axi_aw_req_en), 64'd0);
        k = 0;
        while (w_q.size() < 4 && k < 40) begin
            axi.axi_w_ready = ~axi.axi_w_ready;
            tick();
            k++;
        end
        axi.axi_w_ready = 1'b1;
        repeat (3) tick();
        chk("stall_beats", 64'(w_q.size()), 64'd4);
        chk("stall_aw_count", 64'(aw_q.size()), 64'd1);
        check_burst(0, 0, 1, 8'd3, 32'h5000, 8'h50);

        // User last on beat 5 of an 8-beat burst
        aw_q.delete(); w_q.delete();
        axi.axi_aw_ready = 1'b1;
        for (int b = 0; b < 8; b++) push_data(2, pat(2, b, 8'h60), b == 5);
        push_cmd(2, 8'd7, 32'h6000);
        wait_w(8, 60, "lasterr_beats");
        check_burst(0, 0, 2, 8'd7, 32'h6000, 8'h60);
        chk("lasterr_flag", 64'(wr_last_err), 64'h4);

        // Command and data FIFO overflow with AW held off
        axi.axi_aw_ready = 1'b0;
        for (int n = 0; n < 16; n++) push_cmd(1, 8'd0, 32'h7000 + 32'(n));
        chk("cmd_full_ready", 64'(wr_cmd_ready), 64'hD);
        chk("cmd_full_err0", 64'(wr_cmd_fifo_err), 64'h0);
        push_cmd(1, 8'd0, 32'h7010);
        chk("cmd_ovf_err", 64'(wr_cmd_fifo_err), 64'h2);
        for (int n = 0; n < 16; n++) push_data(3, pat(3, n, 8'h70), 1'b0);
        chk("data_full_ready", 64'(wr_data_ready), 64'h7);
        chk("data_full_err0", 64'(wr_data_fifo_err), 64'h0);
        push_data(3, pat(3, 16, 8'h70), 1'b0);
        chk("data_ovf_err", 64'(wr_data_fifo_err), 64'h8);

        reset_n = 1'b0;
        #1;
        check_quiet("rst2");
        chk("rst2_errs", 64'({wr_data_fifo_err, wr_cmd_fifo_err, wr_last_err}), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("rst2_ready", 64'({wr_cmd_ready, wr_data_ready}), 64'hFF);

        // Partial data for len=7: gating differs by build, then reset mid-burst
        aw_q.delete(); w_q.delete();
        axi.axi_aw_ready = 1'b1;
        axi.axi_w_ready  = 1'b1;
        for (int b = 0; b < 4; b++) push_data(0, pat(0, b, 8'h80), 1'b0);
        push_cmd(0, 8'd7, 32'h8000);
`ifdef WR_BUF_SAF_EN
        repeat (8) tick();
        chk("saf_no_aw", 64'(aw_q.size()), 64'd0);
        chk("saf_no_aw_valid", 64'(axi.axi_aw_req_en), 64'd0);
`else
        wait_w(4, 40, "ct_beats");
        repeat (4) tick();
        chk("ct_w_drop", 64'(axi.axi_w_valid), 64'd0);
        chk("ct_w_count", 64'(w_q.size()), 64'd4);
        chk("ct_aw_count", 64'(aw_q.size()), 64'd1);
`endif
        axi.axi_w_ready = 1'b0;
        for (int b = 4; b < 8; b++) push_data(0, pat(0, b, 8'h80), b == 7);
        k = 0;
        while (!axi.axi_w_valid && k < 20) begin tick(); k++; end
        chk("mid_w_valid", 64'(axi.axi_w_valid), 64'd1);
        chk("mid_aw_count", 64'(aw_q.size()), 64'd1);
`ifdef WR_BUF_SAF_EN
        chk("mid_w_count", 64'(w_q.size()), 64'd0);
`else
        chk("mid_w_count", 64'(w_q.size()), 64'd4);
`endif
        reset_n = 1'b0;
        #1;
        check_quiet("rst3");
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        check_quiet("rst3_after");
        chk("rst3_ready", 64'({wr_cmd_ready, wr_data_ready}), 64'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wr_buffer_mc.md
Name: wr_buffer_mc

Overview:
Single-clock, multi-channel successor to the write buffer. Each of NUM_CH user channels gets its own command FIFO (len+addr) and data FIFO (data+last). A round-robin arbiter serialises the channels onto one AXI write master: AW first, then W. wlast is generated internally from the command length. Optional store-and-forward gating means W never stalls mid-burst for lack of data.

Parameters:
NUM_CH, 4, number of user channels (1..8)
AXI_DATA_WIDTH, 128, data width in bits (64/128/256)
AXI_ADDR_WIDTH, 32, address width in bits
CMD_DEPTH, 16, command FIFO entries per channel (power of 2, >=2)
DATA_DEPTH, 512, data FIFO entries per channel (power of 2, >=2)

Ports:
clk  in  1  single clock for all logic
reset_n  in  1  asynchronous active-low reset
wr_req_en  in  NUM_CH  per-channel command write strobe
wr_burst_length  in  8*NUM_CH  per-channel AXI len (beats-1)
wr_data_addr  in  AXI_ADDR_WIDTH*NUM_CH  per-channel burst start address
wr_cmd_ready  out  NUM_CH  command FIFO not full
wr_data_din  in  AXI_DATA_WIDTH*NUM_CH  per-channel write data
wr_data_valid  in  NUM_CH  per-channel data write strobe
wr_data_last  in  NUM_CH  user marks final beat of burst
wr_data_ready  out  NUM_CH  data FIFO not full
axi_aw_ready  in  1  AW handshake
axi_aw_req_en  out  1  AW valid
axi_aw_burst_len  out  8  AW len
axi_aw_addr  out  AXI_ADDR_WIDTH  AW address
axi_aw_id  out  clog2(NUM_CH) max 1  granted channel index
axi_w_ready  in  1  W handshake
axi_w_valid  out  1  W valid
axi_w_data  out  AXI_DATA_WIDTH  W data
axi_w_last  out  1  W last
wr_data_fifo_err  out  NUM_CH  sticky: data write while full
wr_cmd_fifo_err  out  NUM_CH  sticky: command write while full
wr_last_err  out  NUM_CH  sticky: stored last bit disagrees with generated wlast

Behaviour:
- Reset (reset_n=0, async): all FIFOs emptied, pointers and counts cleared, FSM to IDLE, rr pointer to 0. All AXI outputs and err flags 0; axi_w_data 0; wr_*_ready 1 after release.
- FIFOs: register arrays with first-word-fall-through read. Write is accepted iff the strobe is high and the FIFO is not full at that edge; a simultaneous read in the same cycle does not free a slot for that write. A write while full is dropped and sets the channel's sticky error. Counts are registered; a write is visible to the arbiter the next cycle.
- Eligible[i] = command FIFO i non-empty AND data-readiness condition (see Optional Feature).
- FSM states: IDLE, AW, W.
  - IDLE: if any channel is eligible, grant the first eligible channel at or after rr_ptr (wrapping). Register grant; go to AW. Otherwise stay.
  - AW: axi_aw_req_en=1, len/addr/id from the granted command head, held stable until axi_aw_ready. On handshake: pop the command, load beat_cnt=0 and len_reg=len, go to W.
  - W: axi_w_valid = data FIFO[grant] non-empty. axi_w_data = FIFO head, or 0 when not valid. axi_w_last = valid && (beat_cnt==len_reg). Pop on valid&&ready; beat_cnt++. If the popped entry's last bit != generated wlast, set wr_last_err[grant]. On wlast handshake: rr_ptr=grant+1 mod NUM_CH, go to IDLE.
- Latency: cmd write at cycle N (data ready) -> grant N+1 -> axi_aw_req_en at N+2. There is one IDLE cycle between consecutive bursts.
- Channels not granted accumulate data freely. Ready outputs are independent of the arbiter.
- len=0: single-beat burst; wlast is asserted on the first beat.
- NUM_CH=1: arbiter is degenerate and axi_aw_id is 0.

Optional Feature:
Macro WR_BUF_SAF_EN.
- Defined (store-and-forward): a channel is eligible only when data count >= min(len+1, DATA_DEPTH) for its head command. Bursts longer than DATA_DEPTH are gated on FIFO full. W then never deasserts mid-burst unless the burst exceeds DATA_DEPTH.
- Undefined (cut-through): eligible = command non-empty. axi_w_valid may drop mid-burst while the data FIFO is empty.

Test Plan:
- Ch0 cmd len=3 addr=0x1000 plus 4 beats D0..D3 -> axi_aw_req_en at the cycle given by the latency rule, addr 0x1000, len 3, id 0. Four W beats D0..D3 with axi_w_last only on D3. FSM back to IDLE.
- All 4 channels each post len=1 simultaneously, with data present -> AW ids 0,1,2,3 in order, then rr wraps. A new ch0 cmd posted during ch3's burst is served after ch3.
- axi_aw_ready held low 5 cycles, then axi_w_ready toggling -> AW fields stable throughout; no beat lost or duplicated; wlast on beat len.
- Ch1 writes 17 commands with CMD_DEPTH=16 and no drain -> wr_cmd_ready[1]=0 after 16 writes; wr_cmd_fifo_err[1]=1 on the 17th; the other channels' err flags stay 0.
- Ch2 cmd len=7 but user sets last on beat 5 -> 8 beats issued, wlast on beat 7, wr_last_err[2]=1.
- With WR_BUF_SAF_EN: cmd len=7 and only 4 beats written -> no AW until the 8th beat is written. Without the macro -> AW issued, then axi_w_valid drops after 4 beats. reset_n pulsed low mid-burst -> all outputs 0 immediately and FIFOs empty.
